e203_ifu_predec_fifo: RTL and testbench
=======================================

Name: e203_ifu_predec_fifo

Overview:
- Parametrised successor to the IFU mini-decoder.
- Pre-decodes each fetched instruction (RV32 and RV32C) for branch/jump info and computes a static prediction and target.
- Stores the results with the PC in a DEPTH-entry FIFO, decoupling fetch from the IFU branch-prediction/issue logic with valid/ready handshakes on both sides.
- Sits between the IFU fetch response and the IFU PC-generation/IR stage.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- PC_SIZE, 32, PC width.
- XLEN, 32, immediate/target width; XLEN >= PC_SIZE.
- RFIDX_WIDTH, 5, register index width.
- RVC_EN, 1, 1 = decode compressed instructions; 0 = any non-32-bit encoding decodes as non-branch.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  fetched instruction valid
- i_ready  output  1  FIFO can accept
- i_instr  input  32  instruction; RVC uses [15:0]
- i_pc  input  PC_SIZE  instruction PC
- flush  input  1  discard all entries
- o_valid  output  1  head entry valid
- o_ready  input  1  consumer accepts head
- o_pc  output  PC_SIZE  head PC
- o_rv32  output  1  instr[1:0]==2'b11
- o_jal  output  1  JAL or C.J/C.JAL
- o_jalr  output  1  JALR or C.JR/C.JALR
- o_bxx  output  1  conditional branch (BEQ..BGEU, C.BEQZ/C.BNEZ)
- o_bjp  output  1  o_jal|o_jalr|o_bxx
- o_rs1idx  output  RFIDX_WIDTH  branch/jalr rs1 index
- o_rs2idx  output  RFIDX_WIDTH  branch rs2 index; 0 for RVC
- o_bjp_imm  output  XLEN  sign-extended offset
- o_prdt_taken  output  1  static prediction
- o_prdt_tgt  output  PC_SIZE  i_pc + bjp_imm, truncated to PC_SIZE

Behaviour:
- Reset: all entries, pointers and count cleared. o_valid=0, i_ready=1, all data outputs 0.
- Push when i_valid & i_ready & !flush; pop when o_valid & o_ready & !flush.
- i_ready = !full. No same-cycle pass-through when full. A push and a pop in the same cycle keep count unchanged.
- Latency: an entry pushed in cycle N is presented with o_valid=1 in cycle N+1. No combinational input-to-output path.
- Decode and target addition happen combinationally before the write; all o_* data come from the entry at the read pointer.
- Pointers are log2(DEPTH) bits plus a wrap bit. full = pointers differ only in the wrap bit.
- Empty: o_valid=0; data outputs hold the head-slot contents and are don't-care for the consumer.
- flush: in the same cycle, pointers/count are cleared and any push or pop that cycle is ignored. Next cycle o_valid=0, i_ready=1. Entry contents are not cleared.
- RV32 decode:
  - opcode 1101111 → jal, J-immediate.
  - opcode 1100111 with funct3 000 → jalr, I-immediate, rs1 = [19:15].
  - opcode 1100011 with funct3 not in {010, 011} → bxx, B-immediate, rs1 = [19:15], rs2 = [24:20].
- RVC decode (RVC_EN=1):
  - op 01, funct3 101 (C.J) or 001 (C.JAL) → jal, CJ-immediate.
  - op 10, funct3 100, rs2 field = 0, rs1 field != 0 → jalr (C.JR/C.JALR, selected by [12]), imm 0, rs1 = [11:7].
  - op 01, funct3 110/111 → bxx, CB-immediate, rs1 = {2'b01, [9:7]}.
- Non-branch instructions: bjp flags and immediate are 0, prdt_taken=0.
- Prediction: jal|jalr → taken; bxx taken iff bjp_imm[XLEN-1]=1 (backward branch).
- Target addition wraps modulo 2^PC_SIZE.
- Reset asserted mid-operation clears the FIFO immediately and asynchronously.

Test Plan:
- Reset then one push of i_instr=32'hFE000EE3 (BEQ x0,x0,-4), i_pc=0x100 → next cycle o_valid=1, o_bxx=1, o_bjp_imm=0xFFFFFFFC, o_prdt_taken=1, o_prdt_tgt=0xFC.
- C.J instruction 16'hA001 (offset 0) at i_pc=0x200 → o_jal=1, o_rv32=0, o_bjp_imm=0, o_prdt_tgt=0x200. Repeat with RVC_EN=0 → o_bjp=0.
- JALR x1,0(x5) (32'h000280E7) → o_jalr=1, o_rs1idx=5, o_prdt_taken=1. ADDI → o_bjp=0, o_prdt_taken=0.
- Hold o_ready=0 with DEPTH=2 and push 3 → i_ready=0 after 2 pushes. Third entry accepted the cycle after one pop. Entries emerge in order, including across pointer wrap.
- Full FIFO with i_valid=1 and o_ready=1 asserted together with flush → next cycle o_valid=0, i_ready=1, nothing popped to the consumer.
- Assert rst_n=0 asynchronously mid-stream with 1 entry held → o_valid=0 immediately. After release, the first push behaves as after power-up.

Source files
------------

// File: rtl/e203_ifu_predec_fifo.sv
// IFU pre-decode FIFO: decodes each fetched instruction for branch/jump
// information, computes a static prediction and target, and queues the
// result with its PC so fetch and the PC-generation/IR stage run decoupled.
module e203_ifu_predec_fifo #(
  parameter int DEPTH       = 2,
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RVC_EN      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [31:0]            i_instr,
  input  logic [PC_SIZE-1:0]     i_pc,
  input  logic                   flush,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [PC_SIZE-1:0]     o_pc,
  output logic                   o_rv32,
  output logic                   o_jal,
  output logic                   o_jalr,
  output logic                   o_bxx,
  output logic                   o_bjp,
  output logic [RFIDX_WIDTH-1:0] o_rs1idx,
  output logic [RFIDX_WIDTH-1:0] o_rs2idx,
  output logic [XLEN-1:0]        o_bjp_imm,
  output logic                   o_prdt_taken,
  output logic [PC_SIZE-1:0]     o_prdt_tgt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [PC_SIZE-1:0]     pc;
    logic                   rv32;
    logic                   jal;
    logic                   jalr;
    logic                   bxx;
    logic [RFIDX_WIDTH-1:0] rs1idx;
    logic [RFIDX_WIDTH-1:0] rs2idx;
    logic [XLEN-1:0]        imm;
    logic                   taken;
    logic [PC_SIZE-1:0]     tgt;
  } entry_t;

  // Pre-decode one instruction into a FIFO entry, including the static
  // prediction (jumps taken, backward conditional branches taken) and the
  // PC-relative target, which wraps modulo 2^PC_SIZE.
  function automatic entry_t predec(input logic [31:0] ins,
                                    input logic [PC_SIZE-1:0] pc);
    entry_t e;
    e      = '0;
    e.pc   = pc;
    e.rv32 = (ins[1:0] == 2'b11);
    if (e.rv32) begin
      case (ins[6:0])
        7'b1101111: begin
          e.jal = 1'b1;
          e.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end
        7'b1100111: begin
          if (ins[14:12] == 3'b000) begin
            e.jalr   = 1'b1;
            e.imm    = XLEN'($signed(ins[31:20]));
            e.rs1idx = RFIDX_WIDTH'(ins[19:15]);
          end else begin
            e.jalr = 1'b0;
          end
        end
        7'b1100011: begin
          if ((ins[14:12] != 3'b010) && (ins[14:12] != 3'b011)) begin
            e.bxx    = 1'b1;
            e.imm    = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            e.rs1idx = RFIDX_WIDTH'(ins[19:15]);
            e.rs2idx = RFIDX_WIDTH'(ins[24:20]);
          end else begin
            e.bxx = 1'b0;
          end
        end
        default: begin
          e.jal = 1'b0;
        end
      endcase
    end else if (RVC_EN == 1) begin
      case ({ins[1:0], ins[15:13]})
        5'b01_101, 5'b01_001: begin
          e.jal = 1'b1;
          e.imm = XLEN'($signed({ins[12], ins[8], ins[10:9], ins[6], ins[7],
                                 ins[2], ins[11], ins[5:3], 1'b0}));
        end
        5'b10_100: begin
          // C.JR / C.JALR only; C.MV, C.ADD and C.EBREAK share this slot.
          if ((ins[6:2] == 5'b00000) && (ins[11:7] != 5'b00000)) begin
            e.jalr   = 1'b1;
            e.rs1idx = RFIDX_WIDTH'(ins[11:7]);
          end else begin
            e.jalr = 1'b0;
          end
        end
        5'b01_110, 5'b01_111: begin
          e.bxx    = 1'b1;
          e.imm    = XLEN'($signed({ins[12], ins[6:5], ins[2], ins[11:10],
                                    ins[4:3], 1'b0}));
          e.rs1idx = RFIDX_WIDTH'({2'b01, ins[9:7]});
        end
        default: begin
          e.jal = 1'b0;
        end
      endcase
    end else begin
      e.jal = 1'b0;
    end
    e.taken = e.jal | e.jalr | (e.bxx & e.imm[XLEN-1]);
    e.tgt   = pc + e.imm[PC_SIZE-1:0];
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  entry_t          wdata_s;
  entry_t          head_s;

  assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_s = (wptr_q == rptr_q);
  assign push_s  = i_valid & ~full_s & ~flush;
  assign pop_s   = ~empty_s & o_ready & ~flush;
  assign wdata_s = predec(i_instr, i_pc);

  // Next-state pointers: flush wins over any push/pop in the same cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents survive a flush, only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_s;
    end
  end

  assign head_s       = mem_q[rptr_q[AW-1:0]];
  assign i_ready      = ~full_s;
  assign o_valid      = ~empty_s;
  assign o_pc         = head_s.pc;
  assign o_rv32       = head_s.rv32;
  assign o_jal        = head_s.jal;
  assign o_jalr       = head_s.jalr;
  assign o_bxx        = head_s.bxx;
  assign o_bjp        = head_s.jal | head_s.jalr | head_s.bxx;
  assign o_rs1idx     = head_s.rs1idx;
  assign o_rs2idx     = head_s.rs2idx;
  assign o_bjp_imm    = head_s.imm;
  assign o_prdt_taken = head_s.taken;
  assign o_prdt_tgt   = head_s.tgt;

endmodule

// File: tb/tb_e203_ifu_predec_fifo.sv
// Directed bench for e203_ifu_predec_fifo: decode, ordering, full/flush
// handling and asynchronous reset, with a second instance built without RVC.
module tb_e203_ifu_predec_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        flush;
  logic        o_ready;

  logic        i_ready, o_valid, o_rv32, o_jal, o_jalr, o_bxx, o_bjp, o_prdt_taken;
  logic [31:0] o_pc, o_bjp_imm, o_prdt_tgt;
  logic [4:0]  o_rs1idx, o_rs2idx;

  logic        u1_i_ready, u1_o_valid, u1_o_rv32, u1_o_jal, u1_o_jalr, u1_o_bxx;
  logic        u1_o_bjp, u1_o_prdt_taken;
  logic [31:0] u1_o_pc, u1_o_bjp_imm, u1_o_prdt_tgt;
  logic [4:0]  u1_o_rs1idx, u1_o_rs2idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e203_ifu_predec_fifo dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_instr(i_instr), .i_pc(i_pc), .flush(flush), .o_valid(o_valid),
    .o_ready(o_ready), .o_pc(o_pc), .o_rv32(o_rv32), .o_jal(o_jal),
    .o_jalr(o_jalr), .o_bxx(o_bxx), .o_bjp(o_bjp), .o_rs1idx(o_rs1idx),
    .o_rs2idx(o_rs2idx), .o_bjp_imm(o_bjp_imm), .o_prdt_taken(o_prdt_taken),
    .o_prdt_tgt(o_prdt_tgt)
  );

  e203_ifu_predec_fifo #(.RVC_EN(0)) dut_norvc (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(u1_i_ready),
    .i_instr(i_instr), .i_pc(i_pc), .flush(flush), .o_valid(u1_o_valid),
    .o_ready(o_ready), .o_pc(u1_o_pc), .o_rv32(u1_o_rv32), .o_jal(u1_o_jal),
    .o_jalr(u1_o_jalr), .o_bxx(u1_o_bxx), .o_bjp(u1_o_bjp),
    .o_rs1idx(u1_o_rs1idx), .o_rs2idx(u1_o_rs2idx), .o_bjp_imm(u1_o_bjp_imm),
    .o_prdt_taken(u1_o_prdt_taken), .o_prdt_tgt(u1_o_prdt_tgt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push of a single instruction with the consumer stalled.
  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    i_valid = 1'b1; i_instr = ins; i_pc = pc; o_ready = 1'b0;
    cyc();
    i_valid = 1'b0;
  endtask

  // One-cycle pop of the head entry.
  task automatic pop1();
    o_ready = 1'b1;
    cyc();
    o_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_instr = 32'h0; i_pc = 32'h0;
    flush = 1'b0; o_ready = 1'b0;
    #1;
    check_eq("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check_eq("rst_i_ready", {63'd0, i_ready}, 64'd1);
    check_eq("rst_o_pc", {32'd0, o_pc}, 64'd0);
    check_eq("rst_o_imm", {32'd0, o_bjp_imm}, 64'd0);
    check_eq("rst_o_tgt", {32'd0, o_prdt_tgt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // BEQ x0,x0,-4 at 0x100: backward branch, predicted taken.
    push1(32'hFE000EE3, 32'h100);
    check_eq("beq_valid", {63'd0, o_valid}, 64'd1);
    check_eq("beq_bxx", {63'd0, o_bxx}, 64'd1);
    check_eq("beq_bjp", {63'd0, o_bjp}, 64'd1);
    check_eq("beq_rv32", {63'd0, o_rv32}, 64'd1);
    check_eq("beq_imm", {32'd0, o_bjp_imm}, 64'hFFFFFFFC);
    check_eq("beq_taken", {63'd0, o_prdt_taken}, 64'd1);
    check_eq("beq_tgt", {32'd0, o_prdt_tgt}, 64'hFC);
    check_eq("beq_pc", {32'd0, o_pc}, 64'h100);
    pop1();
    check_eq("beq_popped", {63'd0, o_valid}, 64'd0);

    // C.J offset 0 at 0x200; the no-RVC instance sees a non-branch.
    push1(32'h0000A001, 32'h200);
    check_eq("cj_jal", {63'd0, o_jal}, 64'd1);
    check_eq("cj_rv32", {63'd0, o_rv32}, 64'd0);
    check_eq("cj_imm", {32'd0, o_bjp_imm}, 64'd0);
    check_eq("cj_tgt", {32'd0, o_prdt_tgt}, 64'h200);
    check_eq("cj_taken", {63'd0, o_prdt_taken}, 64'd1);
    check_eq("cj_norvc_bjp", {63'd0, u1_o_bjp}, 64'd0);
    check_eq("cj_norvc_taken", {63'd0, u1_o_prdt_taken}, 64'd0);
    pop1();

    // C.BNEZ x8, -2 (0xFC7D): compressed backward branch, rs1 = x8+1 = x9? no: rs1' field 000 -> x8.
    push1(32'h0000FC7D, 32'h240);
    check_eq("cbnez_bxx", {63'd0, o_bxx}, 64'd1);
    check_eq("cbnez_rs1", {59'd0, o_rs1idx}, 64'd8);
    check_eq("cbnez_imm", {32'd0, o_bjp_imm}, 64'hFFFFFFFE);
    check_eq("cbnez_tgt", {32'd0, o_prdt_tgt}, 64'h23E);
    pop1();

    // JALR x1, 0(x5) at 0x300.
    push1(32'h000280E7, 32'h300);
    check_eq("jalr_jalr", {63'd0, o_jalr}, 64'd1);
    check_eq("jalr_rs1", {59'd0, o_rs1idx}, 64'd5);
    check_eq("jalr_taken", {63'd0, o_prdt_taken}, 64'd1);
    check_eq("jalr_tgt", {32'd0, o_prdt_tgt}, 64'h300);
    pop1();

    // ADDI x1, x0, 1: not a branch.
    push1(32'h00100093, 32'h304);
    check_eq("addi_bjp", {63'd0, o_bjp}, 64'd0);
    check_eq("addi_taken", {63'd0, o_prdt_taken}, 64'd0);
    check_eq("addi_imm", {32'd0, o_bjp_imm}, 64'd0);
    pop1();

    // Fill with the consumer stalled; third push waits for a pop.
    i_valid = 1'b1; i_instr = 32'h00100093; o_ready = 1'b0;
    i_pc = 32'h400; cyc();
    check_eq("fill1_ready", {63'd0, i_ready}, 64'd1);
    i_pc = 32'h404; cyc();
    check_eq("fill2_ready", {63'd0, i_ready}, 64'd0);
    i_pc = 32'h408; cyc();
    check_eq("full_hold_pc", {32'd0, o_pc}, 64'h400);
    check_eq("full_hold_ready", {63'd0, i_ready}, 64'd0);
    o_ready = 1'b1; cyc();
    check_eq("after_pop_pc", {32'd0, o_pc}, 64'h404);
    check_eq("after_pop_ready", {63'd0, i_ready}, 64'd1);
    o_ready = 1'b0; cyc();
    i_valid = 1'b0;
    check_eq("third_in_ready", {63'd0, i_ready}, 64'd0);
    check_eq("order_b_pc", {32'd0, o_pc}, 64'h404);
    pop1();
    check_eq("order_c_pc", {32'd0, o_pc}, 64'h408);
    pop1();
    check_eq("drained", {63'd0, o_valid}, 64'd0);

    // Flush a full FIFO while pushing and popping in the same cycle.
    push1(32'h00100093, 32'h500);
    push1(32'h00100093, 32'h504);
    check_eq("pre_flush_full", {63'd0, i_ready}, 64'd0);
    i_valid = 1'b1; i_pc = 32'h508; o_ready = 1'b1; flush = 1'b1;
    cyc();
    i_valid = 1'b0; o_ready = 1'b0; flush = 1'b0;
    check_eq("flush_valid", {63'd0, o_valid}, 64'd0);
    check_eq("flush_ready", {63'd0, i_ready}, 64'd1);
    push1(32'h000280E7, 32'h600);
    check_eq("post_flush_pc", {32'd0, o_pc}, 64'h600);
    pop1();
    check_eq("post_flush_one", {63'd0, o_valid}, 64'd0);

    // Asynchronous reset with one entry held.
    push1(32'h000280E7, 32'h700);
    check_eq("held_valid", {63'd0, o_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", {63'd0, o_valid}, 64'd0);
    check_eq("async_ready", {63'd0, i_ready}, 64'd1);
    check_eq("async_pc", {32'd0, o_pc}, 64'd0);
    #2 rst_n = 1'b1;
    push1(32'hFE000EE3, 32'h100);
    check_eq("re_valid", {63'd0, o_valid}, 64'd1);
    check_eq("re_tgt", {32'd0, o_prdt_tgt}, 64'hFC);
    check_eq("re_pc", {32'd0, o_pc}, 64'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
